johnson_seq_ctrl: RTL and testbench

Sequencer for an N-stage Johnson (twisted-ring) counter. It owns the ring register and starts, pauses, aborts and single-shots it. It decodes the 2N phases to one-hot strobes for downstream datapath enables. It also validates preloaded ring values and recovers from illegal codes. It sits between the top-level control logic and any block clocked by Johnson phase strobes.

---
 rtl/johnson_seq_pkg.sv | 24 ++
 rtl/johnson_seq_ctrl_ring.sv | 23 ++
 rtl/johnson_seq_ctrl.sv | 112 +++++++++++
 tb/tb_johnson_seq_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/johnson_seq_pkg.sv
// Shared state encoding and Johnson-code helpers for the ring sequencer.
// Helpers take a fixed-width vector plus the live stage count so any N up to NMAX works.
package johnson_seq_pkg;
  localparam int NMAX = 16;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECOVER} state_t;

  // Legal Johnson code: at most one bit-boundary transition across the low n bits.
  function automatic logic is_legal_johnson(input logic [NMAX-1:0] q, input int n);
    int t;
    t = 0;
    for (int i = 1; i < NMAX; i++)
      if (i < n && q[i] != q[i-1]) t++;
    return (t <= 1);
  endfunction

  function automatic int johnson_idx(input logic [NMAX-1:0] q, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < NMAX; i++)
      if (i < n && q[i]) ones++;
    return q[n-1] ? (2*n - ones) : ones;
  endfunction
endpackage

// File: rtl/johnson_seq_ctrl_ring.sv
// N-stage twisted-ring register; clear beats load beats advance.
module johnson_seq_ctrl_ring #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  input  logic         i_adv,
  output logic [N-1:0] o_q
);
  logic [N-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (rst)         r_q <= '0;
    else if (i_clr)  r_q <= '0;
    else if (i_load) r_q <= i_load_val;
    else if (i_adv)  r_q <= {r_q[N-2:0], ~r_q[N-1]};
  end

  assign o_q = r_q;
endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer: run/pause/abort/single-shot FSM, phase decode and load validation.
module johnson_seq_ctrl
  import johnson_seq_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PH = 2*N,
  localparam int IW = $clog2(PH)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_pause,
  input  logic          i_abort,
  input  logic          i_single,
  input  logic          i_load,
  input  logic [N-1:0]  i_load_val,
  output logic [N-1:0]  o_q,
  output logic [PH-1:0] o_phase,
  output logic [IW-1:0] o_phase_idx,
  output logic          o_busy,
  output logic          o_wrap,
  output logic          o_done,
  output logic          o_err
);
  state_t r_state;
  logic   r_single, r_busy, r_wrap, r_done, r_err;
  logic   w_clr, w_load, w_adv, w_load_ok, w_to_zero, w_legal;
  logic [N-1:0] w_q;

  assign w_load_ok = is_legal_johnson(NMAX'(i_load_val), N);
  // The only code whose advance yields all-zero is 10..0.
  assign w_to_zero = (w_q == {1'b1, {(N-1){1'b0}}});

  always_comb begin
    w_clr  = 1'b0;
    w_load = 1'b0;
    w_adv  = 1'b0;
    if (i_abort || r_state == RECOVER) w_clr = 1'b1;
    else if (r_state == IDLE)          w_load = i_load && w_load_ok;
    else if (r_state == RUN)           w_adv  = !i_pause;
  end

  johnson_seq_ctrl_ring #(.N(N)) u_ring (
    .CLK        (CLK),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (i_load_val),
    .i_adv      (w_adv),
    .o_q        (w_q)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= IDLE;
      r_single <= 1'b0;
      r_busy   <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (i_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_load) begin
              r_err <= !w_load_ok;
              if (!w_load_ok) r_state <= RECOVER;
            end else if (i_start) begin
              r_state  <= RUN;
              r_busy   <= 1'b1;
              r_single <= i_single;
            end
          end
          RUN: begin
            if (i_pause) begin
              r_state <= PAUSE;
            end else begin
              r_wrap <= w_to_zero;
              if (w_to_zero && r_single) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (!i_pause && i_start) r_state <= RUN;
          end
          RECOVER: r_state <= IDLE;
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_legal     = is_legal_johnson(NMAX'(w_q), N);
  assign o_q         = w_q;
  assign o_phase_idx = IW'(johnson_idx(NMAX'(w_q), N));
  assign o_phase     = w_legal ? (PH'(1) << o_phase_idx) : '0;
  assign o_busy      = r_busy;
  assign o_wrap      = r_wrap;
  assign o_done      = r_done;
  assign o_err       = r_err;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed-vector bench for johnson_seq_ctrl at N=4 with a short random legality soak.
module tb_johnson_seq_ctrl;
  logic       CLK = 1'b0;
  logic       rst, start, pause, abort, single, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       busy, wrap, done, err;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_seq_ctrl #(.N(4)) dut (
    .CLK(CLK), .rst(rst), .i_start(start), .i_pause(pause), .i_abort(abort),
    .i_single(single), .i_load(load), .i_load_val(load_val),
    .o_q(q), .o_phase(phase), .o_phase_idx(phase_idx), .o_busy(busy),
    .o_wrap(wrap), .o_done(done), .o_err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic legal_q(input logic [3:0] v);
    for (int i = 0; i < 8; i++) if (seq[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst = 1'b1; start = 0; pause = 0; abort = 0; single = 0; load = 0; load_val = '0;
    repeat (3) tick();
    chk("rst_q", q, 0);       chk("rst_phase", phase, 8'h01); chk("rst_idx", phase_idx, 0);
    chk("rst_busy", busy, 0); chk("rst_wrap", wrap, 0);       chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // free-run two revolutions
    start = 1; single = 0; tick(); start = 0;
    chk("fr_busy0", busy, 1); chk("fr_q0", q, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fr_q", q, seq[i%8]);       chk("fr_idx", phase_idx, i%8);
      chk("fr_wrap", wrap, (i%8)==0); chk("fr_done", done, 0);
      chk("fr_busy", busy, 1);
    end

    // abort+start at 1110
    repeat (5) tick();
    chk("ab_pre_q", q, 4'b1110);
    abort = 1; start = 1; tick(); abort = 0; start = 0;
    chk("ab_q", q, 0); chk("ab_busy", busy, 0); chk("ab_wrap", wrap, 0); chk("ab_done", done, 0);

    // single shot
    start = 1; single = 1; tick(); start = 0; single = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("ss_q", q, seq[i%8]); chk("ss_done", done, i==8); chk("ss_wrap", wrap, i==8);
    end
    tick();
    chk("ss_busy_after", busy, 0); chk("ss_q_after", q, 0); chk("ss_done_after", done, 0);

    // pause at 0111
    start = 1; tick(); start = 0;
    repeat (3) tick();
    chk("pa_pre_q", q, 4'b0111);
    pause = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pa_q", q, 4'b0111); chk("pa_phase", phase, 8'b00001000); chk("pa_busy", busy, 1);
    end
    pause = 0; tick();
    chk("pa_rel_nostart_q", q, 4'b0111);
    start = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); start = 0;
      if (q != 4'b0111) break;
    end
    chk("pa_resume_q", q, 4'b1111);
    abort = 1; tick(); abort = 0;

    // loads: legal, illegal + recover, legal again
    load = 1; load_val = 4'b0011; tick(); load = 0;
    chk("ld_q", q, 4'b0011); chk("ld_idx", phase_idx, 2); chk("ld_err", err, 0);
    load = 1; load_val = 4'b0101; tick(); load = 0;
    chk("il_err", err, 1); chk("il_busy", busy, 0); chk("il_q_hold", q, 4'b0011);
    tick();
    chk("rc_q", q, 0); chk("rc_err", err, 1);
    load = 1; load_val = 4'b1100; tick(); load = 0;
    chk("ld2_err", err, 0); chk("ld2_q", q, 4'b1100); chk("ld2_idx", phase_idx, 6);
    chk("ld2_phase", phase, 8'b01000000);

    // load beats start; single shot from preload ends at first return to 0
    load = 1; load_val = 4'b1000; start = 1; tick(); load = 0; start = 0;
    chk("ls_q", q, 4'b1000); chk("ls_busy", busy, 0);
    start = 1; single = 1; tick(); start = 0; single = 0;
    chk("sp_busy", busy, 1);
    tick();
    chk("sp_q", q, 0); chk("sp_done", done, 1); chk("sp_wrap", wrap, 1);
    tick();
    chk("sp_busy_after", busy, 0);

    // load ignored while running, then reset mid-run
    start = 1; tick(); start = 0;
    load = 1; load_val = 4'b1111; tick(); load = 0;
    chk("rl_q", q, 4'b0001);
    tick();
    rst = 1; tick(); rst = 0;
    chk("mr_q", q, 0); chk("mr_phase", phase, 8'h01); chk("mr_busy", busy, 0);
    chk("mr_wrap", wrap, 0); chk("mr_done", done, 0); chk("mr_err", err, 0);

    // random soak
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 31) == 0);
      single   = $urandom_range(0, 1);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      tick();
      chk("rnd_legal", legal_q(q), 1);
      chk("rnd_phase", phase, 8'(1) << phase_idx);
      if (done) chk("rnd_done_wrap_q", {wrap, q}, {1'b1, 4'b0000});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
